// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: request, data-memory and response signals of the MEM-stage load/store unit.
interface mem_stage_lsu_if #(parameter int DW = 32, parameter int AW = 32);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [4:0]    req_rd;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_we;
    logic [DW-1:0] dm_rdata;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [4:0]    resp_rd;
    logic          misalign;
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd, dm_rdata,
        input  req_ready, dm_addr, dm_wdata, dm_we, resp_valid, resp_data, resp_rd, misalign
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd, dm_rdata,
        output req_ready, dm_addr, dm_wdata, dm_we, resp_valid, resp_data, resp_rd, misalign
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with sub-word read-modify-write stores.
// Define LSU_MISALIGN_CHECK_EN to detect and drop misaligned requests.
module mem_stage_lsu #(parameter int DW = 32, parameter int AW = 32) (
    input logic           clk,
    input logic           rst,
    mem_stage_lsu_if.slave lsu
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4,
                           SB = 3'd5, SH = 3'd6, SW = 3'd7;
    state_t        r_state, w_next;
    logic [1:0]    r_off;
    logic [2:0]    r_op;
    logic [4:0]    r_rd;
    logic          w_mis, w_sub;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_ld, w_merge;
    assign lsu.req_ready = (r_state == IDLE);
    assign w_sub = (r_op == SB) || (r_op == SH);
`ifdef LSU_MISALIGN_CHECK_EN
    assign w_mis = ((lsu.req_op == LH || lsu.req_op == LHU || lsu.req_op == SH) && lsu.req_addr[0]) ||
                   ((lsu.req_op == LW || lsu.req_op == SW) && |lsu.req_addr[1:0]);
`else
    assign w_mis = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE && lsu.req_valid && !w_mis) w_next = ACCESS;
        if (r_state == ACCESS && w_sub) w_next = MERGE;
    end
    // Halfword lanes only look at off[1], so unaligned halfwords fold onto their aligned lane.
    always_comb begin
        w_byte  = lsu.dm_rdata[{r_off, 3'b000} +: 8];
        w_half  = lsu.dm_rdata[{r_off[1], 4'b0000} +: 16];
        w_ld    = r_op == LB  ? {{(DW-8){w_byte[7]}}, w_byte} :
                  r_op == LH  ? {{(DW-16){w_half[15]}}, w_half} :
                  r_op == LBU ? {{(DW-8){1'b0}}, w_byte} :
                  r_op == LHU ? {{(DW-16){1'b0}}, w_half} : lsu.dm_rdata;
        w_merge = lsu.dm_rdata;
        if (r_op == SB) w_merge[{r_off, 3'b000} +: 8] = lsu.dm_wdata[7:0];
        else w_merge[{r_off[1], 4'b0000} +: 16] = lsu.dm_wdata[15:0];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lsu.dm_addr    <= '0;
            lsu.dm_wdata   <= '0;
            lsu.dm_we      <= 1'b0;
            lsu.resp_valid <= 1'b0;
            lsu.resp_data  <= '0;
            lsu.resp_rd    <= '0;
            lsu.misalign   <= 1'b0;
            r_off          <= '0;
            r_op           <= '0;
            r_rd           <= '0;
        end else begin
            lsu.dm_we      <= 1'b0;
            lsu.resp_valid <= 1'b0;
            lsu.misalign   <= 1'b0;
            if (r_state == IDLE && lsu.req_valid) begin
                if (w_mis) lsu.misalign <= 1'b1;
                else begin
                    lsu.dm_addr  <= {lsu.req_addr[AW-1:2], 2'b00};
                    lsu.dm_we    <= (lsu.req_op == SW);
                    lsu.dm_wdata <= lsu.req_wdata;
                    r_off        <= lsu.req_addr[1:0];
                    r_op         <= lsu.req_op;
                    r_rd         <= lsu.req_rd;
                end
            end
            if (r_state == ACCESS && r_op <= LHU) begin
                lsu.resp_data  <= w_ld;
                lsu.resp_rd    <= r_rd;
                lsu.resp_valid <= 1'b1;
            end
            if (r_state == ACCESS && w_sub) begin
                lsu.dm_wdata <= w_merge;
                lsu.dm_we    <= 1'b1;
            end
        end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed checks of the MEM-stage LSU against a 64-word behavioural memory.
module tb_mem_stage_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pre = 1'b1;
    logic [31:0] mem [0:63];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, last_acc = 0, prev_acc = 0, cnt_we = 0, cnt_resp = 0, cnt_mis = 0;
    int we0, resp0;
    mem_stage_lsu_if #(.DW(32), .AW(32)) bus();
    mem_stage_lsu #(.DW(32), .AW(32)) dut (.clk(clk), .rst(rst), .lsu(bus.slave));
    always #5 clk = ~clk;
    assign bus.dm_rdata = mem[bus.dm_addr[7:2]];
    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[8]  <= 32'h11223344;
            mem[12] <= 32'h80FF7F01;
            mem[16] <= 32'h0BADBEEF;
            mem[20] <= 32'hCAFEF00D;
        end else if (bus.dm_we) mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dm_we) cnt_we <= cnt_we + 1;
        if (bus.resp_valid) cnt_resp <= cnt_resp + 1;
        if (bus.misalign) cnt_mis <= cnt_mis + 1;
        if (!rst && bus.req_valid && bus.req_ready) begin
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        int k = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_rd    = rd;
        while (!bus.req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10) chk("ready_timeout", 32'(k), 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] exp);
        issue(op, addr, 32'h0, rd);
        @(negedge clk);
        chk({tag, "_busy"}, {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
        chk({tag, "_data"}, bus.resp_data, exp);
        chk({tag, "_rd"}, {27'b0, bus.resp_rd}, {27'b0, rd});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, bus.resp_valid}, 32'd0);
    endtask
    task automatic do_sub(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
        issue(op, addr, wd, 5'd0);
        @(negedge clk);
        chk({tag, "_we_access"}, {31'b0, bus.dm_we}, 32'd0);
        @(negedge clk);
        chk({tag, "_we_merge"}, {31'b0, bus.dm_we}, 32'd1);
        chk({tag, "_ready_merge"}, {31'b0, bus.req_ready}, 32'd0);
        chk({tag, "_wdata"}, bus.dm_wdata, exp);
        @(negedge clk);
        chk({tag, "_we_idle"}, {31'b0, bus.dm_we}, 32'd0);
        chk({tag, "_mem"}, mem[addr[7:2]], exp);
    endtask
    initial begin
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd7;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'hDEADBEEF;
        bus.req_rd    = 5'd3;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_dm_addr", bus.dm_addr, 32'h0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
        chk("rst_resp", {bus.resp_valid, bus.misalign, bus.dm_we, bus.resp_rd}, 32'h0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_no_we", 32'(cnt_we), 32'd0);
        bus.req_valid = 1'b0;
        pre = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        issue(3'd7, 32'h10, 32'h8899AABB, 5'd0);
        issue(3'd2, 32'h10, 32'h0, 5'd9);
        chk("b2b_gap", 32'(last_acc - prev_acc), 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk("lw_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("lw_data", bus.resp_data, 32'h8899AABB);
        chk("lw_rd", {27'b0, bus.resp_rd}, 32'd9);
        @(negedge clk);
        chk("lw_pulse", {31'b0, bus.resp_valid}, 32'd0);
        do_sub("sb", 3'd5, 32'h21, 32'h000000EE, 32'h1122EE44);
        do_sub("sh", 3'd6, 32'h22, 32'h0000BEEF, 32'hBEEFEE44);
        do_load("lb33", 3'd0, 32'h33, 5'd1, 32'hFFFFFF80);
        do_load("lbu33", 3'd3, 32'h33, 5'd2, 32'h00000080);
        do_load("lh30", 3'd1, 32'h30, 5'd4, 32'h00007F01);
        do_load("lh32", 3'd1, 32'h32, 5'd5, 32'hFFFF80FF);
        do_load("lhu32", 3'd4, 32'h32, 5'd31, 32'h000080FF);
`ifdef LSU_MISALIGN_CHECK_EN
        we0 = cnt_we;
        resp0 = cnt_resp;
        issue(3'd2, 32'h41, 32'h0, 5'd7);
        @(negedge clk);
        chk("mis_pulse", {31'b0, bus.misalign}, 32'd1);
        chk("mis_ready", {31'b0, bus.req_ready}, 32'd1);
        issue(3'd2, 32'h40, 32'h0, 5'd8);
        chk("mis_next_gap", 32'(last_acc - prev_acc), 32'd1);
        chk("mis_count", 32'(cnt_mis), 32'd1);
        chk("mis_no_we", 32'(cnt_we - we0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mis_resp_count", 32'(cnt_resp - resp0), 32'd1);
        chk("mis_next_data", bus.resp_data, 32'h0BADBEEF);
`else
        do_load("lw41", 3'd2, 32'h41, 5'd7, 32'h0BADBEEF);
        chk("mis_tied", 32'(cnt_mis), 32'd0);
`endif
        we0 = cnt_we;
        issue(3'd5, 32'h51, 32'h00000077, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_we", {31'b0, bus.dm_we}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_no_we", 32'(cnt_we - we0), 32'd0);
        chk("rst_mid_mem", mem[20], 32'hCAFEF00D);
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the 5-stage pipeline, between the EX/MEM pipeline register and the word-wide data memory. It takes one memory request per instruction and handles byte, halfword and word loads (sign- or zero-extended) and stores. Sub-word stores are done as a read-modify-write over the memory's full-word write port. It stalls the pipeline through a ready handshake and delivers load results, tagged with the destination register, to the MEM/WB register.

## Interface
- DW, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)
- AW, 32, byte-address width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present from EX/MEM
- req_ready  output  1  LSU can accept; high only in IDLE (combinational from state)
- req_op  input  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- req_addr  input  AW  byte address
- req_wdata  input  DW  store data; sub-word stores use the low bits
- req_rd  input  5  load destination register
- dm_addr  output  AW  word-aligned byte address to memory (bits[1:0]=0)
- dm_wdata  output  DW  write data to memory
- dm_we  output  1  memory write enable; memory writes on the rising edge while high
- dm_rdata  input  DW  memory read data, combinational from dm_addr
- resp_valid  output  1  one-cycle pulse: load result valid
- resp_data  output  DW  extended load data
- resp_rd  output  5  destination register of the load
- misalign  output  1  one-cycle pulse: misaligned request dropped

## Operation
- States:
  - IDLE: accept a request on req_valid && req_ready.
  - ACCESS: memory is addressed.
  - MERGE: sub-word stores only; the merged word is written.
- On acceptance, the request is registered. Registered outputs are set as follows:
  - dm_addr <= {req_addr[AW-1:2], 2'b00}
  - dm_we <= (op==SW)
  - dm_wdata <= req_wdata
  - byte offset, op and rd are captured
  - next state is ACCESS
- ACCESS, load: lane select and extension:
  - byte = dm_rdata[8*off +: 8]
  - halfword = dm_rdata[16*off[1] +: 16]
  - LB/LH sign-extend; LBU/LHU zero-extend
  - resp_data and resp_rd are registered, resp_valid <= 1, then IDLE
- ACCESS, SW: the memory writes on this edge. dm_we <= 0, then IDLE.
- ACCESS, SB/SH: dm_rdata is captured and the store lane(s) are replaced, little-endian:
  - SB replaces byte off
  - SH replaces bytes {2*off[1]+1, 2*off[1]}
  - dm_wdata <= merged word, dm_we <= 1, then MERGE
- MERGE: the memory writes on this edge. dm_we <= 0, then IDLE.
- Misalignment, checked at acceptance (see Configuration):
  - LH/LHU/SH with addr[0] != 0
  - LW/SW with addr[1:0] != 0
  - Result: misalign <= 1 for one cycle, no memory access (dm_we stays 0), no resp_valid, state stays IDLE.
- req_valid low in IDLE: no state change, and dm_we, resp_valid and misalign go or stay low.

## Timing
- Reset values: state IDLE, dm_addr 0, dm_wdata 0, dm_we 0, resp_valid 0, resp_data 0, resp_rd 0, misalign 0. Therefore req_ready = 1 during and after reset.
- Load accepted at edge N: resp_valid is high during cycle N+1→N+2 (after edge N+1); req_ready is low for one cycle.
- SW accepted at edge N: memory is written at edge N+1. Occupancy is 2 cycles.
- SB/SH accepted at edge N: read during ACCESS, write at edge N+2. Occupancy is 3 cycles; req_ready is low for 2 cycles.
- Back-to-back requests: the next one is accepted on the first edge where the state is IDLE. A load issued right after a store to the same word returns the updated data.
- Reset asserted mid-operation: the state returns to IDLE and dm_we clears asynchronously. A partially completed RMW never writes.
- Address arithmetic: only bits[1:0] select the lane. Upper bits pass through unchanged, with no wrap handling.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned requests are detected and dropped as described in Operation.
- Not defined: misalign is tied to 0. Low address bits below the access size are ignored:
  - halfword offset uses addr[1] only
  - word accesses use addr[1:0] = 0
- In both cases the access proceeds normally.

## Test plan
- Reset with req_valid high: all outputs are 0, req_ready = 1, and no dm_we pulse appears during reset.
- SW of 0x8899AABB at addr 0x10, then LW at 0x10 → resp_data = 0x8899AABB, resp_rd echoes the request's rd, resp_valid is exactly 1 cycle, and the back-to-back gap is 2 cycles.
- Memory word 0x11223344 at 0x20:
  - SB of 0xEE at 0x21 → word becomes 0x1122EE44
  - then SH of 0xBEEF at 0x22 → word becomes 0xBEEFEE44
  - dm_we is high only in the MERGE cycle
- Word 0x80FF7F01 at 0x30:
  - LB 0x33 → 0xFFFFFF80
  - LBU 0x33 → 0x00000080
  - LH 0x30 → 0x00007F01
  - LH 0x32 → 0xFFFF80FF
  - LHU 0x32 → 0x000080FF
- With LSU_MISALIGN_CHECK_EN: LW at 0x41 → one misalign pulse, no resp_valid, no dm_we, next request accepted the following cycle. Without the macro: LW at 0x41 → data from 0x40.
- Assert rst during the ACCESS cycle of an SB → dm_we is never high, and the memory word is unchanged after reset.
